// File: rtl/cam_pixel_capture.sv
// Camera byte-bus front end: assembles RGB444 byte pairs into 12-bit pixels
// with row/col coordinates, frame markers and a per-frame malformed-line flag.
module cam_pixel_capture #(
  parameter int IMG_WIDTH  = 320,
  parameter int IMG_HEIGHT = 240,
  parameter int COORD_W    = 19
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               cam_vsync_i,
  input  logic               cam_href_i,
  input  logic [7:0]         cam_data_i,
  output logic [11:0]        pix_data_o,
  output logic               pix_valid_o,
  output logic [COORD_W-1:0] row_o,
  output logic [COORD_W-1:0] col_o,
  output logic               frame_start_o,
  output logic               frame_done_o,
  output logic               line_err_o
);

  typedef enum logic [2:0] {
    WAIT_VSYNC,
    VBLANK,
    WAIT_LINE,
    ACTIVE,
    HBLANK
  } state_t;

  localparam logic [COORD_W-1:0] MAX_COL  = COORD_W'(IMG_WIDTH);
  localparam logic [COORD_W-1:0] MAX_ROW  = COORD_W'(IMG_HEIGHT);
  localparam logic [COORD_W-1:0] LAST_COL = COORD_W'(IMG_WIDTH - 1);
  localparam logic [COORD_W-1:0] LAST_ROW = COORD_W'(IMG_HEIGHT - 1);

  state_t             state_q, state_d;
  logic               phase_q, phase_d;
  logic [3:0]         red_q, red_d;
  logic [COORD_W-1:0] row_q, row_d;
  logic [COORD_W-1:0] col_q, col_d;
  logic [11:0]        pix_data_q, pix_data_d;
  logic [COORD_W-1:0] pix_row_q, pix_row_d;
  logic [COORD_W-1:0] pix_col_q, pix_col_d;
  logic               pix_valid_q, pix_valid_d;
  logic               frame_start_q, frame_start_d;
  logic               frame_done_q, frame_done_d;
  logic               line_err_q, line_err_d;
  logic               abort;

  // vsync seen while a frame is in progress; takes priority over any line event
  assign abort = cam_vsync_i &&
                 (state_q == WAIT_LINE || state_q == ACTIVE || state_q == HBLANK);

  always_comb begin
    state_d       = state_q;
    phase_d       = phase_q;
    red_d         = red_q;
    row_d         = row_q;
    col_d         = col_q;
    pix_data_d    = pix_data_q;
    pix_row_d     = pix_row_q;
    pix_col_d     = pix_col_q;
    pix_valid_d   = 1'b0;
    frame_start_d = 1'b0;
    frame_done_d  = 1'b0;
    line_err_d    = line_err_q;

    if (abort) begin
      state_d = VBLANK;
      phase_d = 1'b0;
      if (row_q < MAX_ROW) line_err_d = 1'b1;
    end else begin
      unique case (state_q)
        WAIT_VSYNC: begin
          if (cam_vsync_i) state_d = VBLANK;
        end
        VBLANK: begin
          if (!cam_vsync_i) begin
            frame_start_d = 1'b1;
            line_err_d    = 1'b0;
            row_d         = '0;
            col_d         = '0;
            phase_d       = 1'b0;
            state_d       = WAIT_LINE;
          end
        end
        WAIT_LINE: begin
          if (cam_href_i) begin
            state_d = ACTIVE;
            red_d   = cam_data_i[3:0];
            phase_d = 1'b1;
            col_d   = '0;
          end
        end
        ACTIVE: begin
          if (!cam_href_i) begin
            // short line or a dangling odd byte both mark the frame as malformed
            state_d = HBLANK;
            if (phase_q || col_q < MAX_COL) line_err_d = 1'b1;
          end else if (!phase_q) begin
            red_d   = cam_data_i[3:0];
            phase_d = 1'b1;
          end else begin
            phase_d = 1'b0;
            if (col_q < MAX_COL) begin
              pix_valid_d  = 1'b1;
              pix_data_d   = {red_q, cam_data_i};
              pix_row_d    = row_q;
              pix_col_d    = col_q;
              frame_done_d = (row_q == LAST_ROW) && (col_q == LAST_COL);
              col_d        = col_q + COORD_W'(1);
            end else begin
              line_err_d = 1'b1;
            end
          end
        end
        HBLANK: begin
          if (row_q < MAX_ROW) row_d = row_q + COORD_W'(1);
          col_d   = '0;
          phase_d = 1'b0;
          state_d = (row_q == LAST_ROW) ? WAIT_VSYNC : WAIT_LINE;
        end
        default: state_d = WAIT_VSYNC;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= WAIT_VSYNC;
      phase_q       <= 1'b0;
      red_q         <= '0;
      row_q         <= '0;
      col_q         <= '0;
      pix_data_q    <= '0;
      pix_row_q     <= '0;
      pix_col_q     <= '0;
      pix_valid_q   <= 1'b0;
      frame_start_q <= 1'b0;
      frame_done_q  <= 1'b0;
      line_err_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      phase_q       <= phase_d;
      red_q         <= red_d;
      row_q         <= row_d;
      col_q         <= col_d;
      pix_data_q    <= pix_data_d;
      pix_row_q     <= pix_row_d;
      pix_col_q     <= pix_col_d;
      pix_valid_q   <= pix_valid_d;
      frame_start_q <= frame_start_d;
      frame_done_q  <= frame_done_d;
      line_err_q    <= line_err_d;
    end
  end

  assign pix_data_o    = pix_data_q;
  assign pix_valid_o   = pix_valid_q;
  assign row_o         = pix_row_q;
  assign col_o         = pix_col_q;
  assign frame_start_o = frame_start_q;
  assign frame_done_o  = frame_done_q;
  assign line_err_o    = line_err_q;

endmodule

// File: tb/tb_cam_pixel_capture.sv
// Scoreboard bench for cam_pixel_capture using a reduced 8x6 frame so every
// scenario (full frames, long/short lines, aborts, mid-frame reset) runs quickly.
module tb_cam_pixel_capture;

  localparam int W  = 8;
  localparam int H  = 6;
  localparam int CW = 19;

  typedef struct {
    logic [11:0] data;
    int          row;
    int          col;
    bit          done;
    int          cyc;
  } pix_t;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          vs = 1'b0;
  logic          hr = 1'b0;
  logic [7:0]    dat = 8'h00;
  logic [11:0]   pixData;
  logic          pixValid;
  logic [CW-1:0] rowOut;
  logic [CW-1:0] colOut;
  logic          frameStart;
  logic          frameDone;
  logic          lineErr;

  pix_t expQ[$];
  pix_t got;
  int   cyc = 0;
  int   checks = 0;
  int   passes = 0;
  int   startCount = 0;
  int   doneCount = 0;

  cam_pixel_capture #(.IMG_WIDTH(W), .IMG_HEIGHT(H), .COORD_W(CW)) dut (
    .clk          (clk),
    .reset        (reset),
    .cam_vsync_i  (vs),
    .cam_href_i   (hr),
    .cam_data_i   (dat),
    .pix_data_o   (pixData),
    .pix_valid_o  (pixValid),
    .row_o        (rowOut),
    .col_o        (colOut),
    .frame_start_o(frameStart),
    .frame_done_o (frameDone),
    .line_err_o   (lineErr)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs === exp) passes++;
    else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, obs, exp, cyc);
  endtask

  // Inputs change 1 time unit after the edge; the DUT samples them on the next edge
  task automatic applyStimulus(input logic v, input logic h, input logic [7:0] d);
    @(posedge clk);
    #1;
    vs  = v;
    hr  = h;
    dat = d;
  endtask

  // Pixel outputs are compared at the falling edge against the scoreboard head
  always @(negedge clk) begin
    if (frameStart) startCount++;
    if (pixValid) begin
      if (expQ.size() == 0) begin
        checkOutput("spurious_pix", 32'(pixValid), 32'd0);
      end else begin
        got = expQ.pop_front();
        checkOutput("pix_data", 32'(pixData), 32'(got.data));
        checkOutput("pix_row", 32'(rowOut), 32'(got.row));
        checkOutput("pix_col", 32'(colOut), 32'(got.col));
        checkOutput("pix_done", 32'(frameDone), 32'(got.done));
        checkOutput("pix_latency", 32'(cyc), 32'(got.cyc));
        if (frameDone) doneCount++;
      end
    end else if (frameDone) begin
      checkOutput("stray_done", 32'(frameDone), 32'd0);
    end
  end

  function automatic logic [7:0] byteOf(input int mode, input int i);
    logic [7:0] b;
    if (mode == 0) b = (i % 2 == 0) ? 8'h0A : 8'h5C;
    else begin
      case (i % 4)
        0:       b = 8'h0F;
        1:       b = 8'h00;
        2:       b = 8'h00;
        default: b = 8'hF0;
      endcase
    end
    return b;
  endfunction

  // tail: 0 = href low for 3 cycles, 1 = vsync rises with href fall, 2 = href left high
  task automatic sendLine(input int r, input int nBytes, input int mode, input int tail);
    pix_t p;
    for (int i = 0; i < nBytes; i++) begin
      applyStimulus(1'b0, 1'b1, byteOf(mode, i));
      if (i % 2 == 1 && i / 2 < W) begin
        p.row  = r;
        p.col  = i / 2;
        p.data = (mode == 0) ? 12'hA5C : ((p.col % 2 == 0) ? 12'hF00 : 12'h0F0);
        p.done = (r == H - 1) && (p.col == W - 1);
        p.cyc  = cyc + 1;
        expQ.push_back(p);
      end
    end
    if (tail == 0) repeat (3) applyStimulus(1'b0, 1'b0, 8'h00);
    else if (tail == 1) repeat (3) applyStimulus(1'b1, 1'b0, 8'h00);
  endtask

  task automatic startFrame();
    repeat (3) applyStimulus(1'b1, 1'b0, 8'h00);
    repeat (3) applyStimulus(1'b0, 1'b0, 8'h00);
  endtask

  task automatic sendFrame();
    for (int r = 0; r < H; r++) sendLine(r, 2 * W, 0, 0);
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    repeat (3) applyStimulus(1'b0, 1'b0, 8'h00);
    checkOutput("rst_pix_valid", 32'(pixValid), 32'd0);
    checkOutput("rst_pix_data", 32'(pixData), 32'd0);
    checkOutput("rst_row", 32'(rowOut), 32'd0);
    checkOutput("rst_col", 32'(colOut), 32'd0);
    checkOutput("rst_frame_start", 32'(frameStart), 32'd0);
    checkOutput("rst_frame_done", 32'(frameDone), 32'd0);
    checkOutput("rst_line_err", 32'(lineErr), 32'd0);
    @(posedge clk);
    #1 reset = 1'b0;

    // Full frame; line 0 carries alternating red/green pixels
    startFrame();
    checkOutput("start_cnt_a", 32'(startCount), 32'd1);
    sendLine(0, 2 * W, 1, 0);
    for (int r = 1; r < H; r++) sendLine(r, 2 * W, 0, 0);
    repeat (3) applyStimulus(1'b0, 1'b0, 8'h00);
    checkOutput("line_err_a", 32'(lineErr), 32'd0);
    checkOutput("done_cnt_a", 32'(doneCount), 32'd1);
    checkOutput("queue_a", 32'(expQ.size()), 32'd0);

    // One over-long line and one odd-length line
    startFrame();
    sendLine(0, 2 * W, 0, 0);
    sendLine(1, 2 * W + 2, 0, 0);
    checkOutput("line_err_long", 32'(lineErr), 32'd1);
    sendLine(2, 2 * W, 0, 0);
    sendLine(3, 2 * W - 1, 0, 0);
    sendLine(4, 2 * W, 0, 0);
    sendLine(5, 2 * W, 0, 0);
    repeat (3) applyStimulus(1'b0, 1'b0, 8'h00);
    checkOutput("line_err_b", 32'(lineErr), 32'd1);
    checkOutput("done_cnt_b", 32'(doneCount), 32'd2);
    checkOutput("queue_b", 32'(expQ.size()), 32'd0);

    // Frame aborted mid-line by vsync rising together with href falling
    startFrame();
    checkOutput("line_err_cleared", 32'(lineErr), 32'd0);
    checkOutput("start_cnt_c", 32'(startCount), 32'd3);
    for (int r = 0; r < 3; r++) sendLine(r, 2 * W, 0, 0);
    sendLine(3, 4, 0, 1);
    checkOutput("line_err_abort", 32'(lineErr), 32'd1);
    checkOutput("done_cnt_abort", 32'(doneCount), 32'd2);

    // vsync falls again: a clean frame follows
    repeat (3) applyStimulus(1'b0, 1'b0, 8'h00);
    checkOutput("start_cnt_d", 32'(startCount), 32'd4);
    checkOutput("line_err_d_start", 32'(lineErr), 32'd0);
    sendFrame();
    repeat (3) applyStimulus(1'b0, 1'b0, 8'h00);
    checkOutput("line_err_d", 32'(lineErr), 32'd0);
    checkOutput("done_cnt_d", 32'(doneCount), 32'd2 + 32'd1);
    checkOutput("queue_d", 32'(expQ.size()), 32'd0);

    // Reset in the middle of row 2; bytes keep arriving with vsync low
    startFrame();
    sendLine(0, 2 * W, 0, 0);
    sendLine(1, 2 * W, 0, 0);
    sendLine(2, W, 0, 2);
    @(posedge clk);
    #1 reset = 1'b1;
    repeat (2) applyStimulus(1'b0, 1'b1, 8'h0A);
    @(posedge clk);
    #1 reset = 1'b0;
    for (int i = 0; i < 2 * W; i++) applyStimulus(1'b0, 1'b1, byteOf(0, i));
    repeat (3) applyStimulus(1'b0, 1'b0, 8'h00);
    checkOutput("queue_after_reset", 32'(expQ.size()), 32'd0);
    checkOutput("line_err_after_reset", 32'(lineErr), 32'd0);
    checkOutput("start_cnt_after_reset", 32'(startCount), 32'd5);

    // Capture restarts at row 0, col 0 after a full vsync pulse
    startFrame();
    checkOutput("start_cnt_f", 32'(startCount), 32'd6);
    sendLine(0, 2 * W, 0, 0);
    repeat (3) applyStimulus(1'b0, 1'b0, 8'h00);
    checkOutput("queue_f", 32'(expQ.size()), 32'd0);
    checkOutput("done_cnt_f", 32'(doneCount), 32'd3);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
